serial_adder: RTL



---
 rtl/serial_adder.sv | 78 +++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial 4-bit adder with carry, zero, sign and overflow flags
module serial_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [3:0] sum,
    output logic       cf,
    output logic       zf,
    output logic       sf,
    output logic       of
);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t     r_state;
    logic [3:0] r_a, r_b, r_res;
    logic       r_c;
    logic [1:0] r_cnt;
    logic       w_s, w_co;
    logic [3:0] w_res;
    assign w_s   = r_a[0] ^ r_b[0] ^ r_c;
    assign w_co  = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
    assign w_res = {w_s, r_res[3:1]};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cf      <= 1'b0;
            zf      <= 1'b0;
            sf      <= 1'b0;
            of      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_a     <= a;
                    r_b     <= b;
                    r_res   <= '0;
                    r_c     <= 1'b0;
                    r_cnt   <= '0;
                    busy    <= 1'b1;
                    r_state <= ADD;
                end
                ADD: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_co;
                    r_res <= w_res;
                    r_cnt <= r_cnt + 2'd1;
                    // on the last bit the operand LSBs are the original sign bits
                    if (r_cnt == 2'd3) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        sum     <= w_res;
                        cf      <= w_co;
                        zf      <= (w_res == 4'd0);
                        sf      <= w_s;
                        of      <= (r_a[0] == r_b[0]) && (w_s != r_a[0]);
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
